// File: rtl/mac_driver.sv
// Initiator for the mac streaming protocol. Buffers one N-pair vector, replays it
// to the mac as a start pulse plus N pairs, then returns mac_acc on a result port.
module mac_driver #(
  parameter int N       = 4,
  parameter int TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_x,
  input  logic [15:0] in_w,
  output logic        mac_rst,
  output logic        mac_start,
  output logic [15:0] mac_x,
  output logic [15:0] mac_w,
  input  logic [15:0] mac_acc,
  input  logic        mac_done,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_data,
  output logic        busy,
  output logic        timeout_err
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [PW-1:0] PLAST = PW'(N - 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  localparam logic [1:0] S_LOAD   = 2'd0;
  localparam logic [1:0] S_ISSUE  = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_RESULT = 2'd3;

  logic [1:0]    state;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [TW-1:0] timer;
  logic          to_pulse;
  logic [15:0]   buf_x [N];
  logic [15:0]   buf_w [N];

  assign in_ready = (state == S_LOAD);
  assign busy     = (state != S_LOAD);
  // The watchdog pulse is registered so the mac sees a clean one-cycle reset.
  assign mac_rst  = rst | to_pulse;

  always_ff @(posedge clk) begin
    if (state == S_LOAD && in_valid) begin
      buf_x[wr_ptr] <= in_x;
      buf_w[wr_ptr] <= in_w;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_LOAD;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      timer       <= '0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      timeout_err <= 1'b0;
      to_pulse    <= 1'b0;
    end else begin
      to_pulse <= 1'b0;
      case (state)
        S_LOAD: begin
          if (in_valid) begin
            if (wr_ptr == PLAST) begin
              wr_ptr <= '0;
              rd_ptr <= '0;
              state  <= S_ISSUE;
            end else begin
              wr_ptr <= wr_ptr + 1'b1;
            end
          end
        end
        S_ISSUE: begin
          if (rd_ptr == PLAST) begin
            rd_ptr <= '0;
            timer  <= '0;
            state  <= S_WAIT;
          end else begin
            rd_ptr <= rd_ptr + 1'b1;
          end
        end
        S_WAIT: begin
          // mac_done takes priority over an expiring watchdog in the same cycle.
          if (mac_done) begin
            res_data  <= mac_acc;
            res_valid <= 1'b1;
            state     <= S_RESULT;
          end else if (timer == TLAST) begin
            timeout_err <= 1'b1;
            to_pulse    <= 1'b1;
            state       <= S_LOAD;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_RESULT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= S_LOAD;
          end
        end
        default: state <= S_LOAD;
      endcase
    end
  end

  always_comb begin
    mac_start = 1'b0;
    mac_x     = '0;
    mac_w     = '0;
    if (state == S_ISSUE) begin
      mac_start = (rd_ptr == '0);
      mac_x     = buf_x[rd_ptr];
      mac_w     = buf_w[rd_ptr];
    end
  end

endmodule

// File: tb/tb_mac_driver.sv
// Bench for mac_driver: a behavioural mac stub plus per-scenario tasks checked
// against a golden dot product computed directly from the loaded vectors.
module tb_mac_driver;
  localparam int N = 4;
  localparam int TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_x = '0, in_w = '0;
  logic        mac_rst, mac_start;
  logic [15:0] mac_x, mac_w, mac_acc;
  logic        mac_done;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [15:0] res_data;
  logic        busy, timeout_err;

  int errors = 0;
  int checks = 0;
  logic [15:0] vx [N];
  logic [15:0] vw [N];
  int gaps [N];
  // 0: conforming mac, 1: never done, 2: done at last watchdog cycle with acc=1234
  int mode = 0;

  mac_driver #(.N(N), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_w(in_w), .mac_rst(mac_rst), .mac_start(mac_start),
    .mac_x(mac_x), .mac_w(mac_w), .mac_acc(mac_acc), .mac_done(mac_done),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // mac stub: mcnt counts pairs consumed since start, then keeps counting wait cycles
  int          mcnt = 0;
  logic [15:0] macc = '0;
  always @(posedge clk) begin
    if (mac_rst) begin
      mcnt <= 0;
      macc <= '0;
    end else if (mac_start) begin
      mcnt <= 1;
      macc <= mac_x * mac_w;
    end else if (mcnt != 0) begin
      mcnt <= mcnt + 1;
      if (mcnt < N) macc <= macc + mac_x * mac_w;
    end
  end
  assign mac_done = (mode == 0 && mcnt == N) || (mode == 2 && mcnt == N + TIMEOUT - 1);
  assign mac_acc  = (mode == 2) ? 16'h1234 : macc;

  function automatic logic [15:0] golden();
    int s = 0;
    for (int i = 0; i < N; i++) s += $signed(vx[i]) * $signed(vw[i]);
    return s[15:0];
  endfunction

  task automatic rand_vec(input int maxgap);
    for (int i = 0; i < N; i++) begin
      vx[i] = 16'($urandom);
      vw[i] = 16'($urandom);
      gaps[i] = (maxgap == 0) ? 0 : int'($urandom_range(maxgap, 0));
    end
  endtask

  // Called at a negedge with the DUT in LOAD; returns at the negedge after the last accept.
  task automatic load_vec();
    for (int i = 0; i < N; i++) begin
      for (int g = 0; g < gaps[i]; g++) begin
        in_valid = 1'b0; in_x = 16'($urandom); in_w = 16'($urandom);
        @(posedge clk); @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
          errors++; $display("FAIL gap_idle: in_ready=%b busy=%b want 1 0", in_ready, busy);
        end
      end
      in_valid = 1'b1; in_x = vx[i]; in_w = vw[i];
      checks++;
      if (in_ready !== 1'b1) begin
        errors++; $display("FAIL load_ready[%0d]: in_ready=%b want 1", i, in_ready);
      end
      @(posedge clk); @(negedge clk);
    end
    in_valid = 1'b0; in_x = 16'($urandom); in_w = 16'($urandom);
  endtask

  // Checks the N issue cycles; returns at the negedge of the first wait cycle.
  task automatic check_issue();
    for (int k = 0; k < N; k++) begin
      checks++;
      if (mac_start !== (k == 0) || mac_x !== vx[k] || mac_w !== vw[k] ||
          busy !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL issue[%0d]: start=%b x=%h w=%h busy=%b rdy=%b want %b %h %h 1 0",
                 k, mac_start, mac_x, mac_w, busy, in_ready, (k == 0), vx[k], vw[k]);
      end
      @(negedge clk);
    end
    checks++;
    if (mac_start !== 1'b0 || mac_x !== 16'h0 || mac_w !== 16'h0) begin
      errors++; $display("FAIL post_issue: start=%b x=%h w=%h want 0 0 0", mac_start, mac_x, mac_w);
    end
  endtask

  // lat counts edges after the last accept until res_valid is seen.
  task automatic wait_result(input int exp_lat, input logic [15:0] exp_data);
    int lat = N;
    while (res_valid !== 1'b1 && lat < N + TIMEOUT + 4) begin
      @(negedge clk); lat++;
    end
    checks++;
    if (res_valid !== 1'b1 || lat != exp_lat) begin
      errors++; $display("FAIL result_latency: res_valid=%b lat=%0d want 1 %0d", res_valid, lat, exp_lat);
    end
    checks++;
    if (res_data !== exp_data) begin
      errors++; $display("FAIL result_data: got %h want %h", res_data, exp_data);
    end
  endtask

  task automatic consume();
    res_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++;
    if (res_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL consume: res_valid=%b in_ready=%b busy=%b want 0 1 0", res_valid, in_ready, busy);
    end
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++;
    if (mac_rst !== 1'b1 || in_ready !== 1'b1 || busy !== 1'b0 || res_valid !== 1'b0 ||
        res_data !== 16'h0 || timeout_err !== 1'b0 || mac_start !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: mac_rst=%b rdy=%b busy=%b rv=%b rd=%h terr=%b start=%b want 1 1 0 0 0 0 0",
               mac_rst, in_ready, busy, res_valid, res_data, timeout_err, mac_start);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (mac_rst !== 1'b0) begin
      errors++; $display("FAIL reset_release: mac_rst=%b want 0", mac_rst);
    end
  endtask

  task automatic test_happy();
    for (int i = 0; i < N; i++) begin
      vx[i] = 16'(i + 1); vw[i] = 16'(i + 5); gaps[i] = 0;
    end
    load_vec(); check_issue(); wait_result(N + 1, 16'd70); consume();
  endtask

  task automatic test_backpressure();
    logic [15:0] g;
    res_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL idle_ready: res_valid=%b in_ready=%b want 0 1", res_valid, in_ready);
    end
    res_ready = 1'b0;
    rand_vec(0); g = golden();
    load_vec(); check_issue(); wait_result(N + 1, g);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b1 || res_data !== g || in_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL hold[%0d]: rv=%b rd=%h rdy=%b busy=%b want 1 %h 0 1", c, res_valid, res_data, in_ready, busy, g);
      end
    end
    consume();
  endtask

  task automatic test_gapped();
    // in_valid pattern 1,0,0,1,0,1,1
    rand_vec(0);
    gaps[0] = 0; gaps[1] = 2; gaps[2] = 1; gaps[3] = 0;
    load_vec(); check_issue(); wait_result(N + 1, golden()); consume();
    rand_vec(3);
    load_vec(); check_issue(); wait_result(N + 1, golden()); consume();
  endtask

  task automatic test_watchdog();
    mode = 1;
    rand_vec(0);
    load_vec(); check_issue();
    for (int k = 1; k <= TIMEOUT; k++) begin
      checks++;
      if (busy !== 1'b1 || timeout_err !== 1'b0 || mac_rst !== 1'b0 || res_valid !== 1'b0) begin
        errors++;
        $display("FAIL wait[%0d]: busy=%b terr=%b mac_rst=%b rv=%b want 1 0 0 0", k, busy, timeout_err, mac_rst, res_valid);
      end
      @(negedge clk);
    end
    checks++;
    if (timeout_err !== 1'b1 || mac_rst !== 1'b1 || in_ready !== 1'b1 || res_valid !== 1'b0) begin
      errors++;
      $display("FAIL watchdog_fire: terr=%b mac_rst=%b rdy=%b rv=%b want 1 1 1 0", timeout_err, mac_rst, in_ready, res_valid);
    end
    @(negedge clk);
    checks++;
    if (mac_rst !== 1'b0 || timeout_err !== 1'b1 || res_valid !== 1'b0) begin
      errors++; $display("FAIL watchdog_pulse: mac_rst=%b terr=%b rv=%b want 0 1 0", mac_rst, timeout_err, res_valid);
    end
    mode = 0;
    rand_vec(1);
    load_vec(); check_issue(); wait_result(N + 1, golden()); consume();
    checks++;
    if (timeout_err !== 1'b1) begin
      errors++; $display("FAIL sticky_err: timeout_err=%b want 1", timeout_err);
    end
    test_reset();
  endtask

  task automatic test_done_boundary();
    mode = 2;
    rand_vec(0);
    load_vec(); check_issue(); wait_result(N + TIMEOUT, 16'h1234);
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++; $display("FAIL boundary_err: timeout_err=%b want 0", timeout_err);
    end
    consume();
    mode = 0;
  endtask

  task automatic test_reset_mid();
    rand_vec(0);
    load_vec();
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (mac_rst !== 1'b1) begin
      errors++; $display("FAIL mid_rst_mac_rst: got %b want 1", mac_rst);
    end
    @(posedge clk); @(negedge clk);
    checks++;
    if (mac_start !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || mac_rst !== 1'b1) begin
      errors++;
      $display("FAIL mid_rst: start=%b busy=%b rdy=%b mac_rst=%b want 0 0 1 1", mac_start, busy, in_ready, mac_rst);
    end
    rst = 1'b0;
    @(negedge clk);
    rand_vec(1);
    load_vec(); check_issue(); wait_result(N + 1, golden()); consume();
  endtask

  task automatic test_back_to_back();
    res_ready = 1'b1;
    for (int v = 0; v < 4; v++) begin
      rand_vec(0);
      load_vec(); check_issue(); wait_result(N + 1, golden());
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++; $display("FAIL b2b[%0d]: rv=%b rdy=%b want 0 1", v, res_valid, in_ready);
      end
    end
    res_ready = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_happy();
    test_backpressure();
    test_gapped();
    test_watchdog();
    test_done_boundary();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mac_driver.md
Name: mac_driver

Overview:
Initiator for the `mac` streaming protocol. It buffers one N-element vector pair (x, w) from an upstream valid/ready port. It then replays the pairs to a `mac` instance as a start pulse plus N consecutive pairs, waits for `done`, and presents the accumulated result on a downstream valid/ready port. A watchdog recovers the MAC if `done` never arrives.

Parameters:
N, 4, number of (x, w) pairs per dot product; must match the attached mac's N; N >= 1
TIMEOUT, 8, maximum WAIT cycles without mac_done before the watchdog fires; TIMEOUT >= 2

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  upstream pair valid
in_ready  out  1  upstream pair accepted when in_valid & in_ready
in_x  in  16  signed x element
in_w  in  16  signed w element
mac_rst  out  1  reset to the mac instance
mac_start  out  1  start strobe to the mac
mac_x  out  16  signed x to the mac
mac_w  out  16  signed w to the mac
mac_acc  in  16  signed accumulator from the mac
mac_done  in  1  completion strobe from the mac
res_valid  out  1  result valid
res_ready  in  1  downstream accepts result when res_valid & res_ready
res_data  out  16  signed result, a copy of mac_acc
busy  out  1  high in ISSUE, WAIT and RESULT
timeout_err  out  1  sticky watchdog flag; cleared only by rst

Behaviour:
- Clock and reset: single clock clk. rst is synchronous and active-high.
- Reset values: state=LOAD, wr_ptr=0, rd_ptr=0, timer=0, res_valid=0, res_data=0, timeout_err=0, internal timeout pulse=0. Buffer contents are don't-care.
- mac_rst = rst OR the registered one-cycle timeout pulse. It is high during every rst cycle, so the MAC is cleared with the driver.
- States: LOAD, ISSUE, WAIT, RESULT.
- LOAD:
  - in_ready=1.
  - On each handshake, buf_x[wr_ptr]<=in_x, buf_w[wr_ptr]<=in_w, wr_ptr++.
  - On the handshake at wr_ptr==N-1: wr_ptr<=0, rd_ptr<=0, go to ISSUE.
  - in_ready=0 in every other state.
- ISSUE:
  - mac_x=buf_x[rd_ptr] and mac_w=buf_w[rd_ptr] (registered rd_ptr, combinational read).
  - mac_start=(rd_ptr==0).
  - rd_ptr++ every cycle. In the cycle with rd_ptr==N-1, go to WAIT with timer<=0.
  - Exactly N ISSUE cycles, no gaps.
- Outside ISSUE: mac_start=0, mac_x=0, mac_w=0.
- WAIT:
  - If mac_done=1: res_data<=mac_acc, res_valid<=1, go to RESULT.
  - Otherwise timer++. If timer==TIMEOUT-1: timeout_err<=1, timeout pulse<=1 for one cycle, go to LOAD, and no result is produced.
  - mac_done in any state other than WAIT is ignored.
- RESULT:
  - res_valid=1; res_data is held stable until the handshake.
  - On res_ready: res_valid<=0, go to LOAD.
  - res_ready while res_valid=0 has no effect.
- Latency:
  - Let E0 be the edge that accepts the last pair.
  - mac_start is high in the cycle after E0.
  - With a conforming mac, mac_done is seen in WAIT cycle 1 and res_valid rises at edge E(N+1).
  - If res_ready is held high, throughput is one dot product per 2N+2 cycles.
- N==1: a single ISSUE cycle with mac_start=1, then WAIT.
- Watchdog boundary: if mac_done arrives in the same cycle that timer==TIMEOUT-1, mac_done wins. The result is captured and no error is raised.
- rst mid-operation (any state): return to reset values in the next cycle, discard any partial load and any pending result, and hold mac_rst high for the rst cycles.
- Arithmetic: none in this block; data passes through unmodified as 16-bit two's complement.
- Widths: wr_ptr and rd_ptr are $clog2(N) bits, with a minimum of 1 bit. timer is $clog2(TIMEOUT) bits.

Test Plan:
1. Happy path, N=4, real mac attached, pairs x={1,2,3,4}, w={5,6,7,8} (raw units as interpreted by fixed_mul):
   - mac_start is high exactly once, followed by mac_x 1,2,3,4 on consecutive cycles.
   - res_valid rises 5 edges after the last accept.
   - res_data equals the fixed_mul-based golden sum.
2. Backpressure:
   - Hold res_ready=0 for 10 cycles after res_valid rises.
   - res_valid and res_data stay stable and in_ready stays 0.
   - Assert res_ready: res_valid drops next cycle and in_ready=1.
3. Gapped input:
   - Toggle in_valid 1,0,0,1,0,1,1.
   - Only handshaken pairs are stored, in order; ISSUE starts only after the 4th accept.
4. Watchdog, stub mac that never asserts mac_done, TIMEOUT=8:
   - After 8 WAIT cycles, timeout_err=1 and mac_rst pulses for exactly one cycle.
   - State returns to LOAD with res_valid never set.
   - timeout_err persists through a later successful run until rst.
5. Stub mac asserting mac_done with mac_acc=16'h1234 exactly at timer==TIMEOUT-1:
   - The result is captured as 16'h1234 and timeout_err stays 0.
6. Reset mid-run, rst during the 3rd ISSUE cycle:
   - The next cycle has mac_start=0, busy=0, in_ready=1 and mac_rst high during rst.
   - A following full load of 4 pairs produces the correct result.
